vga_buf_arbiter: RTL and testbench

VGA_BUF_ARBITER -- requirements
Module: vga_buf_arbiter

---
 rtl/vga_buf_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_vga_buf_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_buf_arbiter.sv
// Single-port pixel memory arbiter: display reads take absolute priority, one host queues behind them.
// Define VGA_ARB_HOST_READ_EN to enable host reads; without it every host access is a write.
module vga_buf_arbiter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int AW     = 19,
    parameter int DW     = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          readPixel,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic          host_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rgb,
    output logic [7:0]    max_wait,
    output logic [1:0]    dbg_state
);

    // Host handshake: host_req is taken in IDLE and its fields must stay stable
    // until the single-cycle host_ack; a request still high after RESP starts a new one.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] LP_WIDTH  = WIDTH;
    localparam logic [31:0] LP_HEIGHT = HEIGHT;
    localparam logic [AW:0] LP_NPIX   = (AW+1)'(WIDTH * HEIGHT);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic          r_err;
    logic          r_disp_v;
    logic [DW-1:0] r_rgb;
    logic [7:0]    r_wait_cnt;
    logic [7:0]    r_max_wait;

    logic          w_x_ok;
    logic          w_y_ok;
    logic          w_disp_hit;
    logic [AW-1:0] w_disp_addr;
    logic          w_host_go;
    logic          w_host_mem;
    logic          w_addr_oor;
    logic [7:0]    w_wait_inc;

`ifndef VGA_ARB_HOST_READ_EN
    logic          w_unused;
    assign w_unused = host_we;
`endif

    // Display path is gated by reset so the memory bus is quiet while rst is low.
    assign w_x_ok      = ({22'd0, x} < LP_WIDTH);
    assign w_y_ok      = ({22'd0, y} < LP_HEIGHT);
    assign w_disp_hit  = rst & readPixel & w_x_ok & w_y_ok;
    assign w_disp_addr = AW'(y) * AW'(WIDTH) + AW'(x);
    assign w_addr_oor  = ({1'b0, host_addr} >= LP_NPIX);
    assign w_host_mem  = w_host_go & ~r_err;
    assign w_wait_inc  = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;

    assign rgb       = r_rgb;
    assign max_wait  = r_max_wait;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (host_req)   w_next = ST_WAIT;
            ST_WAIT: if (!readPixel) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        host_ack   = 1'b0;
        host_err   = 1'b0;
        host_rdata = '0;
        w_host_go  = 1'b0;
        case (r_state)
            ST_WAIT: w_host_go = ~readPixel;
            ST_RESP: begin
                host_ack = 1'b1;
                host_err = r_err;
`ifdef VGA_ARB_HOST_READ_EN
                if (!r_we && !r_err) host_rdata = mem_rdata;
`endif
            end
            default: ;
        endcase
    end

    // Display and host grants are mutually exclusive: the host only goes when readPixel is low.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_disp_hit) begin
            mem_en   = 1'b1;
            mem_addr = w_disp_addr;
        end else if (w_host_mem) begin
            mem_en    = 1'b1;
            mem_we    = r_we;
            mem_addr  = r_addr;
            mem_wdata = r_we ? r_wdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else if (r_state == ST_IDLE && host_req) begin
            r_addr  <= host_addr;
`ifdef VGA_ARB_HOST_READ_EN
            r_we    <= host_we;
`else
            r_we    <= 1'b1;
`endif
            r_wdata <= host_wdata;
            r_err   <= w_addr_oor;
        end
    end

    // Read data arrives one cycle after the request; rgb samples it on the following edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_disp_v <= 1'b0;
            r_rgb    <= '0;
        end else begin
            r_disp_v <= w_disp_hit;
            r_rgb    <= r_disp_v ? mem_rdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= 8'd0;
            r_max_wait <= 8'd0;
        end else if (r_state == ST_WAIT && readPixel) begin
            r_wait_cnt <= w_wait_inc;
            if (w_wait_inc > r_max_wait) r_max_wait <= w_wait_inc;
        end else begin
            r_wait_cnt <= 8'd0;
        end
    end

    a_ack_pulse : assert property (@(posedge clk) disable iff (!rst)
        host_ack |=> !host_ack);
    a_idle_bus : assert property (@(posedge clk) disable iff (!rst)
        !mem_en |-> (!mem_we && mem_addr == '0 && mem_wdata == '0));
    a_no_write_in_display : assert property (@(posedge clk) disable iff (!rst)
        mem_we |-> !readPixel);

endmodule

// File: tb/tb_vga_buf_arbiter.sv
// Bench for vga_buf_arbiter: pixel memory emulation, transaction-level reference model
// checked every cycle, plus directed scenarios with hand-computed literals.
module tb_vga_buf_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        readPixel;
    logic        host_req;
    logic        host_we;
    logic [18:0] host_addr;
    logic [11:0] host_wdata;
    logic        host_ack;
    logic [11:0] host_rdata;
    logic        host_err;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata = 12'd0;
    logic [11:0] rgb;
    logic [7:0]  max_wait;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    vga_buf_arbiter dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .readPixel(readPixel),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .host_err(host_err), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rgb(rgb), .max_wait(max_wait), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] pix_init(input int a);
        return 12'(a) ^ 12'h5A5;
    endfunction

    // Pixel memory emulation driven by the DUT bus; junk on mem_rdata when not read.
    logic [11:0] env_mem [int];

    function automatic logic [11:0] env_rd(input int a);
        if (env_mem.exists(a)) return env_mem[a];
        return pix_init(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) env_mem[int'(mem_addr)] = mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= env_rd(int'(mem_addr));
        else                   mem_rdata <= 12'($urandom);
    end

    // Reference model: pending host transaction record, model memory, rgb delay line.
    logic [11:0] mdl_mem [int];
    logic        m_busy, m_granted;
    logic        t_we_m, t_err_m;
    logic [18:0] t_addr_m;
    logic [11:0] t_wdata_m, t_rdata_m;
    int          m_wait_run, m_max;
    logic [11:0] exp_rgb, pend1;
    logic        d_hit, g_hit, a_hit;
    logic        e_en, e_we;
    logic [18:0] e_addr;
    logic [11:0] e_wd, e_rd;

    function automatic logic [11:0] mdl_rd(input int a);
        if (mdl_mem.exists(a)) return mdl_mem[a];
        return pix_init(a);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_mem_en", 32'(mem_en), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
            chk("rst_host_ack", 32'(host_ack), 32'd0);
            chk("rst_host_err", 32'(host_err), 32'd0);
            chk("rst_host_rdata", 32'(host_rdata), 32'd0);
            chk("rst_rgb", 32'(rgb), 32'd0);
            chk("rst_max_wait", 32'(max_wait), 32'd0);
            m_busy = 1'b0; m_granted = 1'b0;
            m_wait_run = 0; m_max = 0;
            exp_rgb = 12'd0; pend1 = 12'd0;
        end else begin
            d_hit = readPixel && (x < 10'd640) && (y < 10'd480);
            g_hit = m_busy && !m_granted && !readPixel;
            a_hit = m_busy && m_granted;
            e_en = 1'b0; e_we = 1'b0; e_addr = 19'd0; e_wd = 12'd0;
            if (d_hit) begin
                e_en = 1'b1;
                e_addr = 19'(int'(y) * 640 + int'(x));
            end else if (g_hit && !t_err_m) begin
                e_en = 1'b1;
                e_we = t_we_m;
                e_addr = t_addr_m;
                e_wd = t_we_m ? t_wdata_m : 12'd0;
            end
            e_rd = (a_hit && !t_we_m && !t_err_m) ? t_rdata_m : 12'd0;
            chk("mem_en", 32'(mem_en), 32'(e_en));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
            chk("host_ack", 32'(host_ack), 32'(a_hit));
            chk("host_err", 32'(host_err), 32'(a_hit && t_err_m));
            chk("host_rdata", 32'(host_rdata), 32'(e_rd));
            chk("rgb", 32'(rgb), 32'(exp_rgb));
            chk("max_wait", 32'(max_wait), 32'(m_max));
            exp_rgb = pend1;
            pend1 = d_hit ? mdl_rd(int'(e_addr)) : 12'd0;
            if (a_hit) begin
                m_busy = 1'b0;
                m_granted = 1'b0;
            end else if (g_hit) begin
                m_granted = 1'b1;
                m_wait_run = 0;
                if (!t_err_m) begin
                    if (t_we_m) mdl_mem[int'(t_addr_m)] = t_wdata_m;
                    else        t_rdata_m = mdl_rd(int'(t_addr_m));
                end
            end else if (m_busy && !m_granted) begin
                m_wait_run = (m_wait_run >= 255) ? 255 : m_wait_run + 1;
                if (m_wait_run > m_max) m_max = m_wait_run;
            end else if (!m_busy && host_req) begin
                m_busy = 1'b1;
                m_granted = 1'b0;
                t_addr_m = host_addr;
                t_wdata_m = host_wdata;
`ifdef VGA_ARB_HOST_READ_EN
                t_we_m = host_we;
`else
                t_we_m = 1'b1;
`endif
                t_err_m = (int'(host_addr) >= 640 * 480);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Both directed tasks start and end just after a rising edge.
    task automatic disp_probe(input logic [9:0] px, input logic [9:0] py, input logic exp_en,
                              input logic [18:0] exp_addr, input logic [11:0] exp_pix, input string nm);
        readPixel = 1'b1; x = px; y = py;
        @(negedge clk);
        chk({nm, "_en"}, 32'(mem_en), 32'(exp_en));
        if (exp_en) chk({nm, "_addr"}, 32'(mem_addr), 32'(exp_addr));
        step();
        readPixel = 1'b0; x = 10'd0; y = 10'd0;
        step();
        @(negedge clk);
        chk({nm, "_rgb"}, 32'(rgb), 32'(exp_pix));
        step();
    endtask

    int          t_lat;
    logic [11:0] t_rd;
    logic        t_er;
    logic        t_gen, t_gwe;
    logic [18:0] t_gaddr;

    task automatic host_txn(input logic we, input logic [18:0] addr, input logic [11:0] wd,
                            input int busy);
        bit done;
        host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
        readPixel = 1'b0;
        t_lat = 0; t_rd = 12'd0; t_er = 1'b0;
        for (int i = 1; i <= busy; i++) begin
            step(); t_lat++;
            readPixel = 1'b1;
            x = (i % 4 == 3) ? 10'd700 : 10'(i);
            y = 10'd3;
        end
        step(); t_lat++;
        readPixel = 1'b0; x = 10'd0; y = 10'd0;
        @(negedge clk);
        t_gen = mem_en; t_gwe = mem_we; t_gaddr = mem_addr;
        step(); t_lat++;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (host_ack) begin
                done = 1'b1;
                t_rd = host_rdata;
                t_er = host_err;
            end
            step();
            if (!done) t_lat++;
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL host_ack_timeout: got no ack expected ack at %0t", $time);
        end
        host_req = 1'b0;
    endtask

    initial begin
        #100000;
        n_cmp++; n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        rst = 1'b0; host_req = 1'b0; host_we = 1'b0; host_addr = 19'd0; host_wdata = 12'd0;
        readPixel = 1'b1; x = 10'd5; y = 10'd2;
        step(); step();
        @(negedge clk);
        chk("reset_state", 32'(dbg_state), 32'd0);
        chk("reset_mem_en_gated", 32'(mem_en), 32'd0);
        chk("reset_rgb", 32'(rgb), 32'd0);
        step();
        rst = 1'b1; readPixel = 1'b0; x = 10'd0; y = 10'd0;
        step();

        disp_probe(10'd5, 10'd2, 1'b1, 19'd1285, 12'h0A0, "disp_5_2");
        disp_probe(10'd0, 10'd480, 1'b0, 19'd0, 12'h000, "disp_y_oor");
        disp_probe(10'd640, 10'd0, 1'b0, 19'd0, 12'h000, "disp_x_oor");

        host_txn(1'b1, 19'd100, 12'hF0F, 0);
        chk("wr_blank_lat", 32'(t_lat), 32'd2);
        chk("wr_blank_gnt_en", 32'(t_gen), 32'd1);
        chk("wr_blank_gnt_we", 32'(t_gwe), 32'd1);
        chk("wr_blank_gnt_addr", 32'(t_gaddr), 32'd100);
        chk("wr_blank_err", 32'(t_er), 32'd0);

        host_txn(1'b1, 19'd200, 12'hABC, 10);
        chk("wr_active_lat", 32'(t_lat), 32'd12);
        chk("wr_active_gnt_addr", 32'(t_gaddr), 32'd200);
        chk("wr_active_max_wait", 32'(max_wait), 32'd10);

        host_txn(1'b1, 19'd307200, 12'h777, 0);
        chk("oor_lat", 32'(t_lat), 32'd2);
        chk("oor_no_mem_en", 32'(t_gen), 32'd0);
        chk("oor_err", 32'(t_er), 32'd1);
        chk("oor_rdata", 32'(t_rd), 32'd0);

        host_txn(1'b0, 19'd100, 12'h123, 0);
        chk("rd_lat", 32'(t_lat), 32'd2);
`ifdef VGA_ARB_HOST_READ_EN
        chk("rd_rdata", 32'(t_rd), 32'hF0F);
        chk("rd_gnt_we", 32'(t_gwe), 32'd0);
        disp_probe(10'd100, 10'd0, 1'b1, 19'd100, 12'hF0F, "after_rd");
`else
        chk("rd_as_wr_rdata", 32'(t_rd), 32'd0);
        chk("rd_as_wr_gnt_we", 32'(t_gwe), 32'd1);
        disp_probe(10'd100, 10'd0, 1'b1, 19'd100, 12'h123, "after_rd_as_wr");
`endif

        host_txn(1'b1, 19'd307199, 12'h456, 2);
        chk("last_pix_lat", 32'(t_lat), 32'd4);
        chk("last_pix_gnt_addr", 32'(t_gaddr), 32'd307199);
        chk("last_pix_max_wait", 32'(max_wait), 32'd10);
        host_txn(1'b1, 19'd0, 12'h001, 260);
        chk("sat_lat", 32'(t_lat), 32'd262);
        chk("sat_max_wait", 32'(max_wait), 32'd255);
        host_txn(1'b1, 19'd1, 12'h002, 0);
        chk("b2b_lat", 32'(t_lat), 32'd2);
        disp_probe(10'd639, 10'd479, 1'b1, 19'd307199, 12'h456, "disp_last");
        disp_probe(10'd0, 10'd0, 1'b1, 19'd0, 12'h001, "disp_first");

        host_req = 1'b1; host_we = 1'b1; host_addr = 19'd50; host_wdata = 12'h999;
        readPixel = 1'b0;
        step();
        readPixel = 1'b1; x = 10'd7; y = 10'd7;
        step(); step();
        chk("pre_rst_state_wait", 32'(dbg_state), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
        chk("mid_rst_rgb", 32'(rgb), 32'd0);
        chk("mid_rst_max_wait", 32'(max_wait), 32'd0);
        chk("mid_rst_ack", 32'(host_ack), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'd0);
        host_req = 1'b0;
        step(); step();
        rst = 1'b1; readPixel = 1'b0; x = 10'd0; y = 10'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_ack", 32'(host_ack), 32'd0);
            chk("post_rst_idle", 32'(dbg_state), 32'd0);
            step();
        end
        disp_probe(10'd50, 10'd0, 1'b1, 19'd50, 12'h597, "dropped_wr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
